multi_edge_flag: RTL
====================

MULTI_EDGE_FLAG -- requirements
Module: multi_edge_flag

Interface
REQ-001 Parameter CH, default 8, number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser flops per channel (1..4).
REQ-003 Parameter FILT_LEN, default 4, consecutive cycles a new level must persist before acceptance (1..255).
REQ-004 Parameter STRETCH, default 1, output pulse width in cycles (1..255).
REQ-005 I_clk  input  1  sole clock; all state updates on rising edge.
REQ-006 I_rst_n  input  1  asynchronous, active-low reset.
REQ-007 I_sig  input  CH  asynchronous signals under detection, bit i = channel i.
REQ-008 I_mode  input  2*CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-009 I_stickyClr  input  CH  per-channel sticky-flag clear, level-sensitive.
REQ-010 O_edgeFlg  output  CH  per-channel registered edge pulse.
REQ-011 O_edgeSticky  output  CH  per-channel latched edge indication.
REQ-012 O_level  output  CH  per-channel filtered (debounced) level.
REQ-013 O_anyEdge  output  1  registered OR of all channels' edge events, same cycle as O_edgeFlg.

Function
REQ-014 Each channel SHALL pass I_sig[i] through SYNC_STAGES flops; last stage = synced level S.
REQ-015 Filter: per-channel counter cnt (width clog2(FILT_LEN+1)); S == O_level -> cnt cleared; S != O_level -> cnt increments; at cnt == FILT_LEN-1 with S still differing, O_level toggles next edge and cnt clears.
REQ-016 FILT_LEN=1 SHALL make O_level follow S with one cycle delay, no suppression.
REQ-017 Glitches on S shorter than FILT_LEN cycles SHALL NOT change O_level.
REQ-018 Edge event = O_level transition matching I_mode (0->1 for 01/11, 1->0 for 10/11); mode 00 produces no events while O_level still tracks.
REQ-019 O_edgeFlg[i] SHALL assert the cycle after O_level[i] changes and hold STRETCH cycles; total latency from first sampling edge of a stable input change = SYNC_STAGES + FILT_LEN + 1 edges.
REQ-020 A new event during an active stretch SHALL reload the stretch counter to STRETCH; no gap, no extension beyond STRETCH after last event.
REQ-021 O_anyEdge SHALL be the single-cycle OR of edge events (not stretched), coincident with the first cycle of the corresponding O_edgeFlg.
REQ-022 O_edgeSticky[i] sets on an edge event (same cycle as O_edgeFlg rise), clears when I_stickyClr[i]=1; simultaneous set and clear -> set wins.
REQ-023 I_mode changes SHALL take effect on the next O_level transition only; a mode change alone SHALL NOT create an event.
REQ-024 Channels SHALL be fully independent; simultaneous events on any subset all reported in the same cycle.

Reset
REQ-025 I_rst_n low SHALL immediately clear all synchroniser flops, cnt, stretch counters, O_level, O_edgeFlg, O_edgeSticky, O_anyEdge to 0.
REQ-026 Reset assertion mid-stretch or mid-filter SHALL abort it with no residual pulse after release.
REQ-027 Input held high across reset release SHALL yield a rising event after the REQ-019 latency (O_level starts at 0).

Structure
REQ-028 Shared package SHALL hold mode encodings (MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH) and parameter range limits.
REQ-029 Per-channel logic SHALL live in sub-module edge_flag_chan, instantiated CH times via generate; top holds only O_anyEdge reduction.

Verification (CH=4, SYNC_STAGES=2, FILT_LEN=3, STRETCH=2, latency 6)
REQ-030 Ch0 mode 01, I_sig[0] 0->1 held -> O_level[0] high after 5 edges, O_edgeFlg[0] high edges 6-7, O_anyEdge high edge 6 only, O_edgeSticky[0]=1.
REQ-031 Ch1 mode 11, 2-cycle high glitch -> no O_level, O_edgeFlg, sticky change; 3-cycle high pulse -> rise event then fall event 3 cycles apart.
REQ-032 Ch2 mode 10, stable 1->0 -> one falling pulse; same with mode 00 -> no pulse, O_level[2] still falls.
REQ-033 Ch3 sticky set and I_stickyClr[3]=1 in same cycle -> sticky stays 1; clear next cycle -> 0.
REQ-034 I_rst_n low during O_edgeFlg stretch -> all outputs 0 immediately; I_sig held 4'hF through release -> all four channels in mode 01 pulse together 6 edges after release.
REQ-035 Events on ch0 at cycle t and t+1 (toggle input with FILT_LEN=1 build) -> O_edgeFlg[0] continuous, ends STRETCH cycles after last event.

Source files
------------

// File: rtl/multi_edge_flag_pkg.sv
// ============================================================================
// multi_edge_flag_pkg : mode encodings, parameter limits and event helper
// Rev 1.0
// ============================================================================
`default_nettype none

package multi_edge_flag_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  localparam int CH_MIN      = 1;
  localparam int CH_MAX      = 32;
  localparam int SYNC_MIN    = 1;
  localparam int SYNC_MAX    = 4;
  localparam int FILT_MIN    = 1;
  localparam int FILT_MAX    = 255;
  localparam int STRETCH_MIN = 1;
  localparam int STRETCH_MAX = 255;

  function automatic logic edge_match(input logic [1:0] mode,
                                      input logic       rise,
                                      input logic       fall);
    return (rise && (mode == MODE_RISE || mode == MODE_BOTH)) ||
           (fall && (mode == MODE_FALL || mode == MODE_BOTH));
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_flag_chan.sv
// ============================================================================
// edge_flag_chan : one channel - synchroniser, debounce filter, edge pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module edge_flag_chan
  import multi_edge_flag_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int STRETCH     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig,
  input  logic [1:0] mode,
  input  logic       sticky_clr,
  output logic       edge_flg,
  output logic       edge_sticky,
  output logic       level,
  output logic       edge_evt
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);
  localparam int STR_W = $clog2(STRETCH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FILT_LEN - 1);
  localparam logic [STR_W-1:0] STR_RELOAD = STR_W'(STRETCH - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_W-1:0]       cnt;
  logic                   level_d;
  logic [STR_W-1:0]       str_cnt;

  assign synced   = sync_q[SYNC_STAGES-1];
  // Events come from the accepted level, so a mode change alone never fires
  assign edge_evt = edge_match(mode, level & ~level_d, ~level & level_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      cnt         <= '0;
      level       <= 1'b0;
      level_d     <= 1'b0;
      str_cnt     <= '0;
      edge_flg    <= 1'b0;
      edge_sticky <= 1'b0;
    end else begin
      sync_q[0] <= sig;
      for (int j = 1; j < SYNC_STAGES; j++) begin
        sync_q[j] <= sync_q[j-1];
      end

      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      level_d <= level;

      // A new event restarts the full stretch window
      if (edge_evt) begin
        edge_flg <= 1'b1;
        str_cnt  <= STR_RELOAD;
      end else if (str_cnt != '0) begin
        str_cnt <= str_cnt - 1'b1;
      end else begin
        edge_flg <= 1'b0;
      end

      if (edge_evt) begin
        edge_sticky <= 1'b1;
      end else if (sticky_clr) begin
        edge_sticky <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/multi_edge_flag.sv
// ============================================================================
// multi_edge_flag : CH independent debounced edge detectors with any-edge OR
// Rev 1.0
// ============================================================================
`default_nettype none

module multi_edge_flag
  import multi_edge_flag_pkg::*;
#(
  parameter int CH          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int STRETCH     = 1
) (
  input  logic            I_clk,
  input  logic            I_rst_n,
  input  logic [CH-1:0]   I_sig,
  input  logic [2*CH-1:0] I_mode,
  input  logic [CH-1:0]   I_stickyClr,
  output logic [CH-1:0]   O_edgeFlg,
  output logic [CH-1:0]   O_edgeSticky,
  output logic [CH-1:0]   O_level,
  output logic            O_anyEdge
);

  logic [CH-1:0] edge_evt;

  generate
    for (genvar i = 0; i < CH; i++) begin : g_chan
      edge_flag_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN),
        .STRETCH     (STRETCH)
      ) u_chan (
        .clk         (I_clk),
        .rst_n       (I_rst_n),
        .sig         (I_sig[i]),
        .mode        (I_mode[2*i +: 2]),
        .sticky_clr  (I_stickyClr[i]),
        .edge_flg    (O_edgeFlg[i]),
        .edge_sticky (O_edgeSticky[i]),
        .level       (O_level[i]),
        .edge_evt    (edge_evt[i])
      );
    end
  endgenerate

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_anyEdge <= 1'b0;
    end else begin
      O_anyEdge <= |edge_evt;
    end
  end

endmodule

`default_nettype wire
